// File: rtl/pjw_pkg.sv
// Shared types and constants for the PJW hash engine requester.
// Optional expect/match datapath is enabled by defining PJW_REQ_CHECK_EN.
package pjw_pkg;

  localparam int WORD_W             = 32;
  localparam int ENGINE_BUSY_CYCLES = 5;
  localparam int ERR_CNT_W          = 8;

`ifdef PJW_REQ_CHECK_EN
  localparam int FIFO_W = 2 * WORD_W;
`else
  localparam int FIFO_W = WORD_W;
`endif

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    WAIT_BUSY,
    WAIT_DONE,
    RESULT
  } pjw_state_e;

  function automatic logic [ERR_CNT_W-1:0] sat_inc(input logic [ERR_CNT_W-1:0] v);
    return (v == '1) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/pjw_req_fifo.sv
// Synchronous FIFO with show-ahead read data and extra-MSB wrap-around pointers.
module pjw_req_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_wdata,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_rdata,
  output logic             o_full,
  output logic             o_empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW:0]      r_wr_ptr;
  logic [AW:0]      r_rd_ptr;
  logic             w_do_push;
  logic             w_do_pop;

  assign o_empty   = (r_wr_ptr == r_rd_ptr);
  assign o_full    = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                     (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign w_do_push = i_push && !o_full;
  assign w_do_pop  = i_pop && !o_empty;
  assign o_rdata   = r_mem[r_rd_ptr[AW-1:0]];

  // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

  // NOTE: storage is not reset; the pointers alone define which entries are valid.
  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr[AW-1:0]] <= i_wdata;
  end

endmodule

// File: rtl/pjw_requester.sv
// Initiator for one PJW hash engine: buffers words, issues jobs, supervises with a timeout.
// Define PJW_REQ_CHECK_EN to carry an expected hash per word and flag out_match.
module pjw_requester
  import pjw_pkg::*;
#(
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 15
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WORD_W-1:0]    in_data,
`ifdef PJW_REQ_CHECK_EN
  input  logic [WORD_W-1:0]    in_expect,
`endif
  output logic                 pjw_valid,
  output logic [WORD_W-1:0]    pjw_data,
  input  logic                 pjw_ready,
  input  logic [WORD_W-1:0]    pjw_result,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [WORD_W-1:0]    out_word,
  output logic [WORD_W-1:0]    out_hash,
`ifdef PJW_REQ_CHECK_EN
  output logic                 out_match,
`endif
  output logic                 err,
  output logic [ERR_CNT_W-1:0] err_cnt
);

  localparam logic [7:0] TIMER_MAX = 8'(TIMEOUT);

  pjw_state_e        r_state;
  pjw_state_e        w_next_state;
  logic [7:0]        r_timer;
  logic [7:0]        w_timer_next;
  logic              w_push;
  logic              w_pop;
  logic              w_capture;
  logic              w_out_clr;
  logic              w_timeout;
  logic              w_full;
  logic              w_empty;
  logic [FIFO_W-1:0] w_fifo_wdata;
  logic [FIFO_W-1:0] w_fifo_rdata;

`ifdef PJW_REQ_CHECK_EN
  logic [WORD_W-1:0] r_expect;
  assign w_fifo_wdata = {in_expect, in_data};
`else
  assign w_fifo_wdata = in_data;
`endif

  assign in_ready  = !w_full;
  assign w_push    = in_valid && in_ready;
  assign pjw_valid = (r_state == ISSUE);
  assign err       = w_timeout;

  pjw_req_fifo #(
    .WIDTH (FIFO_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (w_push),
    .i_wdata (w_fifo_wdata),
    .i_pop   (w_pop),
    .o_rdata (w_fifo_rdata),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_timer <= '0;
    end else begin
      r_state <= w_next_state;
      r_timer <= w_timer_next;
    end
  end

  // NOTE: every output of this block gets a default first, so no path can infer a latch.
  always_comb begin
    w_next_state = r_state;
    w_pop        = 1'b0;
    w_capture    = 1'b0;
    w_out_clr    = 1'b0;
    w_timeout    = 1'b0;
    w_timer_next = '0;
    unique case (r_state)
      IDLE: begin
        // The engine is never reset from here, so wait for it to report idle.
        if (!w_empty && pjw_ready) begin
          w_pop        = 1'b1;
          w_next_state = ISSUE;
        end
      end
      ISSUE: w_next_state = WAIT_BUSY;
      WAIT_BUSY: begin
        if (!pjw_ready) begin
          w_next_state = WAIT_DONE;
        end else if (r_timer == TIMER_MAX) begin
          w_timeout    = 1'b1;
          w_next_state = IDLE;
        end
      end
      WAIT_DONE: begin
        if (pjw_ready) begin
          w_capture    = 1'b1;
          w_next_state = RESULT;
        end else if (r_timer == TIMER_MAX) begin
          w_timeout    = 1'b1;
          w_next_state = IDLE;
        end
      end
      RESULT: begin
        if (out_ready) begin
          w_out_clr = 1'b1;
          if (!w_empty) begin
            w_pop        = 1'b1;
            w_next_state = ISSUE;
          end else begin
            w_next_state = IDLE;
          end
        end
      end
      default: w_next_state = IDLE;
    endcase
    if ((w_next_state == r_state) && ((r_state == WAIT_BUSY) || (r_state == WAIT_DONE)))
      w_timer_next = r_timer + 8'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pjw_data  <= '0;
      out_valid <= 1'b0;
      out_word  <= '0;
      out_hash  <= '0;
      err_cnt   <= '0;
`ifdef PJW_REQ_CHECK_EN
      r_expect  <= '0;
      out_match <= 1'b0;
`endif
    end else begin
      if (w_pop) begin
        pjw_data <= w_fifo_rdata[WORD_W-1:0];
`ifdef PJW_REQ_CHECK_EN
        r_expect <= w_fifo_rdata[FIFO_W-1:WORD_W];
`endif
      end
      if (w_capture) begin
        out_valid <= 1'b1;
        out_word  <= pjw_data;
        out_hash  <= pjw_result;
`ifdef PJW_REQ_CHECK_EN
        out_match <= (pjw_result == r_expect);
`endif
      end else if (w_out_clr) begin
        out_valid <= 1'b0;
      end
      if (w_timeout) err_cnt <= sat_inc(err_cnt);
    end
  end

endmodule

// File: tb/tb_pjw_requester.sv
// Self-checking bench for pjw_requester: behavioural engine model plus in-order scoreboard.
`timescale 1ns/1ps
module tb_pjw_requester;
  import pjw_pkg::*;

  localparam int DEPTH   = 4;
  localparam int TIMEOUT = 15;

  typedef struct {
    logic [31:0] word;
    logic [31:0] hash;
    logic        match;
  } job_t;

  typedef enum {ENG_NORMAL, ENG_STALL, ENG_STUCK, ENG_HANG} eng_mode_e;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_data = '0;
  logic        pjw_valid;
  logic [31:0] pjw_data;
  logic        eng_ready = 1'b1;
  logic [31:0] eng_result = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_word;
  logic [31:0] out_hash;
  logic        err;
  logic [7:0]  err_cnt;
`ifdef PJW_REQ_CHECK_EN
  logic [31:0] in_expect = '0;
  logic        out_match;
`endif

  always #5 clk = ~clk;

  pjw_requester #(
    .DEPTH   (DEPTH),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
`ifdef PJW_REQ_CHECK_EN
    .in_expect  (in_expect),
`endif
    .pjw_valid  (pjw_valid),
    .pjw_data   (pjw_data),
    .pjw_ready  (eng_ready),
    .pjw_result (eng_result),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_word   (out_word),
    .out_hash   (out_hash),
`ifdef PJW_REQ_CHECK_EN
    .out_match  (out_match),
`endif
    .err        (err),
    .err_cnt    (err_cnt)
  );

  int          n_vec = 0;
  int          n_bad = 0;
  job_t        exp_q[$];
  int          hs_cyc[$];
  eng_mode_e   eng_mode = ENG_NORMAL;
  int          eng_busy = 0;
  logic [31:0] eng_pending = '0;
  logic [31:0] cur_expect = '0;
  int          cyc = 0;
  int          valid_pulses = 0;
  int          err_pulses = 0;
  int          hs_cnt = 0;
  int          wb_entry_cyc = 0;
  int          last_err_cyc = 0;
  logic        last_push = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Classic PJW/ELF hash over the four bytes, most significant byte first.
  function automatic logic [31:0] pjw_ref(input logic [31:0] w);
    logic [31:0] h;
    logic [31:0] g;
    h = '0;
    for (int i = 3; i >= 0; i--) begin
      h = (h << 4) + 32'(w[i*8 +: 8]);
      g = h & 32'hF000_0000;
      if (g != 0) h = h ^ (g >> 24);
      h = h & ~g;
    end
    return h;
  endfunction

  // One clock: record pre-edge handshakes, advance engine model, score completed outputs.
  task automatic tick();
    logic        psh, acc, pv, odn, om;
    logic [31:0] pd, ow, oh;
    job_t        j, e;
    psh     = in_valid && in_ready;
    acc     = pjw_valid && eng_ready;
    pv      = pjw_valid;
    pd      = pjw_data;
    odn     = out_valid && out_ready;
    ow      = out_word;
    oh      = out_hash;
`ifdef PJW_REQ_CHECK_EN
    om      = out_match;
`else
    om      = 1'b0;
`endif
    j.word  = in_data;
    j.hash  = pjw_ref(in_data);
    j.match = (j.hash == cur_expect);
    @(posedge clk);
    #1;
    cyc++;
    last_push = psh;
    if (psh) exp_q.push_back(j);
    if (pv) begin
      valid_pulses++;
      wb_entry_cyc = cyc;
    end
    check("pjw_valid_single_cycle", 32'(pjw_valid && pv), 0);
    if (odn) begin
      hs_cnt++;
      hs_cyc.push_back(cyc);
      if (exp_q.size() == 0) begin
        check("unexpected_output", 1, 0);
      end else begin
        e = exp_q.pop_front();
        check("sb_out_word", ow, e.word);
        check("sb_out_hash", oh, e.hash);
`ifdef PJW_REQ_CHECK_EN
        check("sb_out_match", 32'(om), 32'(e.match));
`else
        if (om) check("sb_out_match", 32'(om), 0);
`endif
      end
    end
    case (eng_mode)
      ENG_NORMAL: begin
        if (eng_busy > 0) begin
          eng_busy--;
          if (eng_busy == 0) begin
            eng_ready  = 1'b1;
            eng_result = eng_pending;
          end
        end else if (acc) begin
          eng_ready   = 1'b0;
          eng_busy    = ENGINE_BUSY_CYCLES;
          eng_pending = pjw_ref(pd);
          eng_result  = $urandom;
        end
      end
      ENG_STALL: eng_ready = 1'b0;
      ENG_STUCK: eng_ready = 1'b1;
      ENG_HANG:  if (acc) eng_ready = 1'b0;
      default:   eng_ready = 1'b1;
    endcase
    #1;
    if (err) begin
      err_pulses++;
      last_err_cyc = cyc;
      if (exp_q.size() > 0) void'(exp_q.pop_front());
    end
  endtask

  task automatic do_reset(input eng_mode_e mode);
    in_valid   = 1'b0;
    in_data    = '0;
    out_ready  = 1'b0;
    eng_mode   = mode;
    eng_busy   = 0;
    eng_ready  = (mode != ENG_STALL);
    eng_result = '0;
    rst_n      = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    exp_q.delete();
    hs_cyc.delete();
    valid_pulses = 0;
    err_pulses   = 0;
    hs_cnt       = 0;
    rst_n        = 1'b1;
    #1;
  endtask

  task automatic push_word(input logic [31:0] w, input logic [31:0] x, input int max_cyc);
    int n;
    n          = 0;
    in_valid   = 1'b1;
    in_data    = w;
    cur_expect = x;
`ifdef PJW_REQ_CHECK_EN
    in_expect  = x;
`endif
    last_push  = 1'b0;
    while (!last_push && n < max_cyc) begin
      tick();
      n++;
    end
    in_valid = 1'b0;
    if (!last_push) check("push_accept_timeout", 0, 1);
  endtask

  task automatic wait_out(input int max_cyc, output int n);
    n = 0;
    while (!out_valid && n < max_cyc) begin
      tick();
      n++;
    end
    if (!out_valid) check("out_valid_timeout", 0, 1);
  endtask

  task automatic drain(input int max_cyc);
    int n;
    n = 0;
    while ((exp_q.size() > 0 || out_valid) && n < max_cyc) begin
      tick();
      n++;
    end
    check("drain_empty", 32'(exp_q.size()), 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    logic [31:0] d;

    // Reset state
    do_reset(ENG_NORMAL);
    check("rst_in_ready", 32'(in_ready), 1);
    check("rst_pjw_valid", 32'(pjw_valid), 0);
    check("rst_pjw_data", pjw_data, 0);
    check("rst_out_valid", 32'(out_valid), 0);
    check("rst_out_word", out_word, 0);
    check("rst_out_hash", out_hash, 0);
    check("rst_err", 32'(err), 0);
    check("rst_err_cnt", 32'(err_cnt), 0);
`ifdef PJW_REQ_CHECK_EN
    check("rst_out_match", 32'(out_match), 0);
`endif

    // Single job latency: push at edge 0, ISSUE after edge 1, out_valid after edge 8
    out_ready = 1'b1;
    push_word(32'h0102_0304, 32'h0000_1234, 4);
    tick();
    check("issue_after_edge1", 32'(pjw_valid), 1);
    wait_out(20, n);
    check("result_latency", 32'(n + 1), 7 + 1);
    check("t1_out_word", out_word, 32'h0102_0304);
    check("t1_out_hash", out_hash, 32'h0000_1234);
`ifdef PJW_REQ_CHECK_EN
    check("t1_out_match", 32'(out_match), 1);
`endif
    drain(20);

    // Back-to-back pair: in-order results, one pulse each, 8 cycles apart
    valid_pulses = 0;
    hs_cyc.delete();
    push_word(32'h4142_4344, 32'h0, 2);
    push_word(32'h0000_0000, 32'h0, 2);
    wait_out(20, n);
    check("t2_hash_a", out_hash, 32'h0004_5674);
    tick();
    wait_out(20, n);
    check("t2_hash_b", out_hash, 32'h0000_0000);
    check("t2_word_b", out_word, 32'h0000_0000);
    drain(20);
    check("t2_handshakes", 32'(hs_cyc.size()), 2);
    if (hs_cyc.size() == 2) check("t2_throughput", 32'(hs_cyc[1] - hs_cyc[0]), 8);
    check("t2_pjw_pulses", 32'(valid_pulses), 2);

    // Engine stalled from reset: FIFO fills, no bypass, nothing lost on release
    do_reset(ENG_STALL);
    out_ready = 1'b1;
    for (int i = 0; i < DEPTH; i++) push_word($urandom, 32'h0, 4);
    check("stall_in_ready_low", 32'(in_ready), 0);
    in_valid = 1'b1;
    in_data  = 32'hCAFE_F00D;
    repeat (3) tick();
    check("stall_no_issue", 32'(valid_pulses), 0);
    check("stall_no_push", 32'(last_push), 0);
    eng_mode  = ENG_NORMAL;
    eng_ready = 1'b1;
    push_word(32'hCAFE_F00D, 32'h0, 20);
    drain(200);
    check("stall_all_done", 32'(hs_cnt), 32'(DEPTH + 1));

    // Engine ignores pjw_valid: WAIT_BUSY timeout
    do_reset(ENG_STUCK);
    out_ready = 1'b1;
    push_word(32'h1111_2222, 32'h0, 4);
    n = 0;
    while (err_pulses == 0 && n < 60) begin
      tick();
      n++;
    end
    check("busy_timeout_seen", 32'(err_pulses), 1);
    check("busy_timeout_latency", 32'(last_err_cyc - wb_entry_cyc), TIMEOUT);
    tick();
    check("busy_timeout_err_cnt", 32'(err_cnt), 1);
    check("err_one_cycle", 32'(err), 0);
    repeat (10) tick();
    check("busy_timeout_no_out", 32'(out_valid), 0);
    check("busy_timeout_no_hs", 32'(hs_cnt), 0);

    // Engine accepts but never finishes: WAIT_DONE timeout
    eng_mode = ENG_HANG;
    push_word(32'h3333_4444, 32'h0, 4);
    n = 0;
    while (err_pulses < 2 && n < 60) begin
      tick();
      n++;
    end
    check("done_timeout_seen", 32'(err_pulses), 2);
    check("done_timeout_latency", 32'(last_err_cyc - wb_entry_cyc), TIMEOUT + 1);
    tick();
    check("done_timeout_err_cnt", 32'(err_cnt), 2);
    check("done_timeout_no_out", 32'(out_valid), 0);

    // err_cnt saturation
    do_reset(ENG_STUCK);
    out_ready = 1'b1;
    for (int i = 0; i < 256; i++) push_word($urandom, 32'h0, 60);
    drain(6000);
    tick();
    check("sat_err_pulses", 32'(err_pulses), 256);
    check("sat_err_cnt", 32'(err_cnt), 255);

    // Downstream backpressure holds result and blocks further issue
    do_reset(ENG_NORMAL);
    out_ready = 1'b0;
    push_word(32'h0102_0304, 32'h0, 4);
    push_word(32'h4142_4344, 32'h0, 4);
    wait_out(20, n);
    n = valid_pulses;
    for (int i = 0; i < 20; i++) begin
      tick();
      check("hold_out_valid", 32'(out_valid), 1);
      check("hold_out_word", out_word, 32'h0102_0304);
      check("hold_out_hash", out_hash, 32'h0000_1234);
    end
    check("hold_no_issue", 32'(valid_pulses), 32'(n));
    out_ready = 1'b1;
    tick();
    check("release_issue", 32'(pjw_valid), 1);
    drain(40);

`ifdef PJW_REQ_CHECK_EN
    // Expected-hash comparison
    push_word(32'h0102_0304, 32'h0000_1234, 4);
    wait_out(20, n);
    check("match_true", 32'(out_match), 1);
    drain(20);
    push_word(32'h0102_0304, 32'h0000_1235, 4);
    wait_out(20, n);
    check("match_false", 32'(out_match), 0);
    drain(20);
`endif

    // Randomized traffic against the scoreboard
    do_reset(ENG_NORMAL);
    for (int i = 0; i < 1500; i++) begin
      d          = $urandom;
      in_valid   = ($urandom_range(0, 1) == 1);
      in_data    = d;
      cur_expect = ($urandom_range(0, 1) == 1) ? pjw_ref(d) : $urandom;
`ifdef PJW_REQ_CHECK_EN
      in_expect  = cur_expect;
`endif
      out_ready  = ($urandom_range(0, 9) < 7);
      tick();
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    drain(400);
    check("rand_progress", 32'(hs_cnt > 50), 1);
    check("rand_no_err", 32'(err_cnt), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
